// File: rtl/core_v_mini_mcu_pkg.sv
// Pad ring side enumeration shared with the MCU top level.
package core_v_mini_mcu_pkg;

  typedef enum logic [1:0] {
    TOP    = 2'b00,
    RIGHT  = 2'b01,
    BOTTOM = 2'b10,
    LEFT   = 2'b11
  } pad_side_e;

endpackage

// File: rtl/pad_cell_pkg.sv
// Shared types and attribute field offsets for the input pad cell filter.
package pad_cell_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10,
    BOTH = 2'b11
  } edge_mode_e;

  localparam int ATTR_FILT_EN  = 0;
  localparam int ATTR_INVERT   = 1;
  localparam int ATTR_EDGE_LSB = 2;
  localparam int ATTR_THR_LSB  = 4;

endpackage

// File: rtl/pad_filt_channel.sv
// One input pad channel: synchroniser, debounce filter, polarity, edge pulse and sticky pending flag.
module pad_filt_channel
  import pad_cell_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pad,
  input  logic             filt_en,
  input  logic             invert,
  input  edge_mode_e       edge_mode,
  input  logic [CNT_W-1:0] thr,
  input  logic             edge_clr,
  output logic             pad_out,
  output logic             pad_sync,
  output logic             edge_pulse,
  output logic             edge_pending
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stable;
  logic                   stable_d;
  logic                   stable_q;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_d;
  logic [CNT_W-1:0]       eff_thr;
  logic [CNT_W:0]         count_inc;
  logic                   thr_hit;
  logic                   rise_raw;
  logic                   fall_raw;
  logic                   rise_q;
  logic                   fall_q;
  logic                   rise_en;
  logic                   fall_en;

  // Shift the raw pad value through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  assign pad_sync = sync_q[SYNC_STAGES-1];

  // A threshold of zero behaves as one; the extra counter bit keeps the compare wrap-free.
  assign eff_thr   = (thr == '0) ? CNT_W'(1) : thr;
  assign count_inc = {1'b0, count} + (CNT_W+1)'(1);
  assign thr_hit   = (count_inc >= {1'b0, eff_thr});

  // Debounce decision: accept a new level only after it persists eff_thr cycles.
  always_comb begin
    stable_d = stable;
    count_d  = count;
    if (!filt_en) begin
      stable_d = pad_sync;
      count_d  = '0;
    end else if (pad_sync == stable) begin
      count_d  = '0;
    end else if (thr_hit) begin
      stable_d = pad_sync;
      count_d  = '0;
    end else begin
      count_d  = count_inc[CNT_W-1:0];
    end
  end

  // Filter state, previous stable level for edge detection, and sticky pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable       <= 1'b0;
      stable_q     <= 1'b0;
      count        <= '0;
      edge_pending <= 1'b0;
    end else begin
      stable       <= stable_d;
      stable_q     <= stable;
      count        <= count_d;
      edge_pending <= (edge_pending & ~edge_clr) | edge_pulse;
    end
  end

  assign pad_out  = stable ^ invert;
  assign rise_raw = stable & ~stable_q;
  assign fall_raw = ~stable & stable_q;

  // Edges are reported in pad_out polarity, so inversion swaps rise and fall.
  assign rise_q     = invert ? fall_raw : rise_raw;
  assign fall_q     = invert ? rise_raw : fall_raw;
  assign rise_en    = (edge_mode == RISE) || (edge_mode == BOTH);
  assign fall_en    = (edge_mode == FALL) || (edge_mode == BOTH);
  assign edge_pulse = (rise_q & rise_en) | (fall_q & fall_en);

endmodule

// File: rtl/pad_cell_input_filt.sv
// Multi-channel input pad cell: per-channel synchronise, debounce, polarity and edge flagging.
module pad_cell_input_filt
  import pad_cell_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int PADATTR     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter core_v_mini_mcu_pkg::pad_side_e SIDE = core_v_mini_mcu_pkg::TOP
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NCH-1:0]         pad_io,
  input  logic [NCH*PADATTR-1:0] pad_attributes_i,
  input  logic [NCH-1:0]         edge_clr_i,
  output logic [NCH-1:0]         pad_out_o,
  output logic [NCH-1:0]         pad_sync_o,
  output logic [NCH-1:0]         edge_o,
  output logic [NCH-1:0]         edge_pending_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pad_cell_input_filt: SYNC_STAGES must be at least 2");
  end
  if (CNT_W > PADATTR - ATTR_THR_LSB) begin : g_bad_cnt
    $error("pad_cell_input_filt: CNT_W must be at most PADATTR-4");
  end
  if (PADATTR < 12) begin : g_bad_attr
    $error("pad_cell_input_filt: PADATTR must be at least 12");
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [PADATTR-1:0] attr;
    assign attr = pad_attributes_i[k*PADATTR +: PADATTR];

    if (PADATTR > ATTR_THR_LSB + CNT_W) begin : g_rsv
      logic unused_rsv;
      assign unused_rsv = ^attr[PADATTR-1:ATTR_THR_LSB+CNT_W];
    end

    pad_filt_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk          (clk_i),
      .rst          (rst_i),
      .pad          (pad_io[k]),
      .filt_en      (attr[ATTR_FILT_EN]),
      .invert       (attr[ATTR_INVERT]),
      .edge_mode    (edge_mode_e'(attr[ATTR_EDGE_LSB +: 2])),
      .thr          (attr[ATTR_THR_LSB +: CNT_W]),
      .edge_clr     (edge_clr_i[k]),
      .pad_out      (pad_out_o[k]),
      .pad_sync     (pad_sync_o[k]),
      .edge_pulse   (edge_o[k]),
      .edge_pending (edge_pending_o[k])
    );
  end

endmodule

// File: tb/tb_pad_cell_input_filt.sv
// Directed self-checking bench for the input pad cell filter.
module tb_pad_cell_input_filt;

  localparam int NCH     = 4;
  localparam int PADATTR = 16;

  localparam logic [1:0] M_NONE = 2'b00;
  localparam logic [1:0] M_RISE = 2'b01;
  localparam logic [1:0] M_BOTH = 2'b11;

  logic                   clk;
  logic                   rst;
  logic [NCH-1:0]         pad;
  logic [PADATTR-1:0]     attr [NCH];
  logic [NCH*PADATTR-1:0] pad_attributes;
  logic [NCH-1:0]         edge_clr;
  logic [NCH-1:0]         pad_out;
  logic [NCH-1:0]         pad_sync;
  logic [NCH-1:0]         edge_pulse;
  logic [NCH-1:0]         edge_pending;

  int checks   = 0;
  int failures = 0;

  assign pad_attributes = {attr[3], attr[2], attr[1], attr[0]};

  pad_cell_input_filt #(
    .NCH         (NCH),
    .PADATTR     (PADATTR),
    .SYNC_STAGES (2),
    .CNT_W       (8),
    .SIDE        (core_v_mini_mcu_pkg::TOP)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pad_io           (pad),
    .pad_attributes_i (pad_attributes),
    .edge_clr_i       (edge_clr),
    .pad_out_o        (pad_out),
    .pad_sync_o       (pad_sync),
    .edge_o           (edge_pulse),
    .edge_pending_o   (edge_pending)
  );

  // Free-running core clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [PADATTR-1:0] mk_attr(input logic filt, input logic inv,
                                                 input logic [1:0] mode, input logic [7:0] thr);
    mk_attr = {4'b0000, thr, mode, inv, filt};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance n clock edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    pad      = '0;
    edge_clr = '0;
    for (int i = 0; i < NCH; i++) attr[i] = '0;
    tick(2);
    check_output("rst_pad_out", pad_out, 4'h0);
    check_output("rst_pad_sync", pad_sync, 4'h0);
    check_output("rst_edge", edge_pulse, 4'h0);
    check_output("rst_pending", edge_pending, 4'h0);
    rst = 1'b0;

    // ch0 unfiltered rise
    attr[0] = mk_attr(1'b0, 1'b0, M_RISE, 8'd0);
    tick(3);
    pad[0] = 1'b1;
    tick(1);
    check_output("ch0_sync_c1", pad_sync[0], 1'b0);
    tick(1);
    check_output("ch0_sync_c2", pad_sync[0], 1'b1);
    check_output("ch0_out_c2", pad_out[0], 1'b0);
    tick(1);
    check_output("ch0_out_c3", pad_out[0], 1'b1);
    check_output("ch0_edge_c3", edge_pulse[0], 1'b1);
    tick(1);
    check_output("ch0_edge_c4", edge_pulse[0], 1'b0);
    check_output("ch0_pend_c4", edge_pending[0], 1'b1);

    // ch1 glitch shorter than threshold is dropped
    attr[1] = mk_attr(1'b1, 1'b0, M_RISE, 8'd4);
    tick(2);
    pad[1] = 1'b1;
    tick(3);
    pad[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_output("ch1_glitch_out", pad_out[1], 1'b0);
      check_output("ch1_glitch_edge", edge_pulse[1], 1'b0);
      tick(1);
    end

    // ch1 pulse of exactly the threshold is accepted at cycle 6
    pad[1] = 1'b1;
    tick(4);
    pad[1] = 1'b0;
    check_output("ch1_out_c4", pad_out[1], 1'b0);
    tick(1);
    check_output("ch1_out_c5", pad_out[1], 1'b0);
    tick(1);
    check_output("ch1_out_c6", pad_out[1], 1'b1);
    check_output("ch1_edge_c6", edge_pulse[1], 1'b1);
    tick(10);
    check_output("ch1_out_settled", pad_out[1], 1'b0);

    // ch2 inverted, edges follow pad_out polarity
    attr[2] = mk_attr(1'b0, 1'b1, M_RISE, 8'd0);
    pad[2] = 1'b1;
    tick(5);
    check_output("ch2_out_hi_pad", pad_out[2], 1'b0);
    check_output("ch2_no_pend", edge_pending[2], 1'b0);
    pad[2] = 1'b0;
    tick(2);
    check_output("ch2_out_c2", pad_out[2], 1'b0);
    tick(1);
    check_output("ch2_out_c3", pad_out[2], 1'b1);
    check_output("ch2_edge_c3", edge_pulse[2], 1'b1);
    tick(1);
    check_output("ch2_edge_c4", edge_pulse[2], 1'b0);
    attr[2] = mk_attr(1'b0, 1'b0, M_RISE, 8'd0);
    #1;
    check_output("ch2_inv_flip", pad_out[2], 1'b0);
    check_output("ch2_inv_noedge", edge_pulse[2], 1'b0);
    tick(1);
    check_output("ch2_inv_noedge_next", edge_pulse[2], 1'b0);

    // ch3 set wins over simultaneous clear, then clear alone
    attr[3] = mk_attr(1'b0, 1'b0, M_BOTH, 8'd0);
    tick(2);
    pad[3] = 1'b1;
    tick(3);
    check_output("ch3_edge_c3", edge_pulse[3], 1'b1);
    edge_clr[3] = 1'b1;
    tick(1);
    check_output("ch3_pend_setwins", edge_pending[3], 1'b1);
    check_output("ch3_edge_c4", edge_pulse[3], 1'b0);
    tick(1);
    check_output("ch3_pend_cleared", edge_pending[3], 1'b0);
    edge_clr[3] = 1'b0;

    // ch3 filtered with thr 0 behaves like thr 1
    attr[3] = mk_attr(1'b1, 1'b0, M_BOTH, 8'd0);
    tick(2);
    pad[3] = 1'b0;
    tick(2);
    check_output("ch3_thr0_c2", pad_out[3], 1'b1);
    tick(1);
    check_output("ch3_thr0_c3", pad_out[3], 1'b0);
    check_output("ch3_thr0_edge", edge_pulse[3], 1'b1);

    // ch1 threshold lowered mid-count, no wrap afterwards
    attr[1] = mk_attr(1'b1, 1'b0, M_NONE, 8'd200);
    tick(2);
    pad[1] = 1'b1;
    tick(52);
    check_output("ch1_thr200_c52", pad_out[1], 1'b0);
    attr[1] = mk_attr(1'b1, 1'b0, M_NONE, 8'd10);
    tick(1);
    check_output("ch1_thr10_accept", pad_out[1], 1'b1);
    check_output("ch1_none_noedge", edge_pulse[1], 1'b0);
    pad[1] = 1'b0;
    tick(11);
    check_output("ch1_nowrap_c11", pad_out[1], 1'b1);
    tick(1);
    check_output("ch1_nowrap_c12", pad_out[1], 1'b0);

    // reset mid-count discards progress
    attr[1] = mk_attr(1'b1, 1'b0, M_RISE, 8'd4);
    tick(2);
    pad[1] = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(1);
    check_output("mid_rst_pad_out", pad_out, 4'h0);
    check_output("mid_rst_sync", pad_sync, 4'h0);
    check_output("mid_rst_edge", edge_pulse, 4'h0);
    check_output("mid_rst_pending", edge_pending, 4'h0);
    rst = 1'b0;
    tick(5);
    check_output("post_rst_out_c11", pad_out[1], 1'b0);
    tick(1);
    check_output("post_rst_out_c12", pad_out[1], 1'b1);
    check_output("post_rst_edge_c12", edge_pulse[1], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pad_cell_input_filt.md
Name: pad_cell_input_filt

Overview:
- Multi-channel input pad cell for the ASIC pad ring.
- Passes each pad value into the core through a metastability synchroniser and an optional per-channel debounce filter, with selectable polarity.
- Produces per-channel edge pulses and sticky edge-pending flags, which feed the GPIO/interrupt logic.
- Instantiated per pad group at a given SIDE; replaces direct pad-to-core wiring for asynchronous inputs.

Parameters:
- NCH, 4, number of input channels.
- PADATTR, 16, attribute bits per channel; minimum 12.
- SYNC_STAGES, 2, synchroniser flops per channel; minimum 2.
- CNT_W, 8, debounce counter width; must be at most PADATTR-4.
- SIDE, core_v_mini_mcu_pkg::TOP, pad ring side (core_v_mini_mcu_pkg::pad_side_e); informational, no logic effect.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset, synchronous, active-high.
- pad_io  in  NCH  raw asynchronous pad values.
- pad_attributes_i  in  NCH*PADATTR  per-channel attributes; channel k occupies [k*PADATTR +: PADATTR].
- edge_clr_i  in  NCH  clears edge_pending_o[k]; level-sampled each cycle.
- pad_out_o  out  NCH  synchronised, filtered, polarity-applied value.
- pad_sync_o  out  NCH  synchroniser output, unfiltered.
- edge_o  out  NCH  one-cycle pulse on a qualified edge.
- edge_pending_o  out  NCH  sticky edge flag.

Behaviour:
- Attribute fields per channel:
  - bit0 filt_en.
  - bit1 invert.
  - bits[3:2] edge_mode: 00 none, 01 rise, 10 fall, 11 both.
  - bits[4+CNT_W-1:4] thr.
  - Remaining bits reserved and ignored.
- Reset (rst_i high at a clk_i edge):
  - Sync flops, stable, stable_q, counter and pending all clear to 0.
  - Outputs after reset: pad_out_o = 0 ^ invert (combinational from invert), pad_sync_o = 0, edge_o = 0, edge_pending_o = 0.
  - Reset mid-count discards the count.
- Synchroniser: pad_sync_o is pad_io delayed by SYNC_STAGES flops. There is no reset bypass.
- Filter, filt_en = 0: stable <= pad_sync_o every cycle; counter held at 0.
- Filter, filt_en = 1, with eff_thr = max(thr, 1):
  - If pad_sync_o == stable: counter <= 0.
  - Else if counter + 1 >= eff_thr: stable <= pad_sync_o, counter <= 0.
  - Else: counter <= counter + 1.
  - A change must persist eff_thr consecutive cycles to be accepted. Shorter glitches are dropped.
  - The counter never wraps, because the >= comparison also covers thr lowered mid-count.
- Latency from a pad_io change to pad_out_o: SYNC_STAGES + 1 cycles when unfiltered; SYNC_STAGES + eff_thr cycles when filtered.
- Polarity: pad_out_o = stable ^ invert (combinational). Toggling invert changes pad_out_o immediately and generates no edge.
- Edge detection: stable_q <= stable every cycle.
  - rise_raw = stable & ~stable_q; fall_raw = ~stable & stable_q.
  - When invert = 1, rise and fall are swapped, so edges refer to pad_out_o polarity.
  - edge_o[k] is asserted combinationally in the first cycle pad_out_o shows the new value, if that edge type is enabled by edge_mode.
- Pending: edge_pending_o <= (edge_pending_o & ~edge_clr_i) | edge_o.
  - Set wins over a simultaneous clear.
  - A clear held high for several cycles keeps the flag low except in cycles where an edge occurs.
- Changing edge_mode or filt_en mid-operation takes effect on the next cycle. No spurious edge is generated except by a real stable transition.
- Channels are fully independent; there are no cross-channel interactions.

Decomposition:
- Package pad_cell_pkg:
  - edge_mode_e enum (NONE, RISE, FALL, BOTH).
  - Attribute bit-offset localparams: ATTR_FILT_EN = 0, ATTR_INVERT = 1, ATTR_EDGE_LSB = 2, ATTR_THR_LSB = 4.
  - pad_side_e is reused from core_v_mini_mcu_pkg.
- Sub-module pad_filt_channel (one channel: synchroniser, debounce counter, edge and pending logic).
  - The top level is a generate loop over NCH plus attribute slicing and parameter checks (SYNC_STAGES >= 2, CNT_W <= PADATTR-4).

Test Plan:
- Reset, then ch0 filt_en = 0, pad_io[0] 0→1 at cycle 0 -> pad_sync_o[0] = 1 at cycle 2; pad_out_o[0] = 1 at cycle 3; edge_o[0] pulses at cycle 3 with edge_mode = RISE.
- ch1 filt_en = 1, thr = 4, pad_io[1] high-pulse lasting 3 cycles -> pad_out_o[1] stays 0 and no edge. A 4-cycle pulse -> pad_out_o[1] rises at cycle 2 + 4 = 6.
- ch2 invert = 1, edge_mode = RISE, pad_io[2] 1→0 -> pad_out_o[2] rises and edge_o[2] pulses. Toggling invert alone -> pad_out_o flips with no edge_o.
- ch3 edge_mode = BOTH, an edge occurs in the same cycle edge_clr_i[3] = 1 -> edge_pending_o[3] = 1 next cycle. Clear with no edge -> 0 next cycle.
- thr = 200 mid-count at counter = 50, then thr rewritten to 10 -> stable updates on the next mismatching cycle; counter returns to 0 with no wrap.
- rst_i asserted mid-filter with counter = 3 -> all outputs return to reset values next cycle; after release, the pad must again persist thr cycles before pad_out_o changes.
